// File: rtl/soc_system_pwm_pll_ctrl.sv
// Lock/reset sequencer for the PWM-domain PLL.
// Pulses the PLL reset, waits for a synchronised lock, requires that lock to
// stay stable for a minimum time before declaring the PWM clock ready, and
// retries on lock timeout until the retry budget is exhausted (FAULT).
// Everything runs in the 50 MHz reference domain; all outputs are registered.
module soc_system_pwm_pll_ctrl #(
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 17
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       sw_restart,
    output logic       pll_rst,
    output logic       pll_ready,
    output logic       fault,
    output logic [7:0] relock_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RESET_PLL  = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABLE_CHK = 3'd2,
        S_RUN        = 3'd3,
        S_FAULT      = 3'd4
    } state_t;

    // Terminal counts for the shared cycle counter.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             relock_inc;
    logic [1:0]       sync_q;
    logic             locked_s;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, which is what makes this a two-stage shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign locked_s = sync_q[1];

    // Next-state, counter and retry bookkeeping; sw_restart overrides everything.
    // NOTE: every variable gets a default at the top so no path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        relock_inc = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE_CHK;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d   = '0;
                    retry_d = retry_q + 4'd1;
                    state_d = (retry_q + 4'd1 == RETRY_MAX) ? S_FAULT : S_RESET_PLL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STABLE_CHK: begin
                // Any drop in lock restarts both the stability window and the timeout.
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d    = S_RESET_PLL;
                    cnt_d      = '0;
                    relock_inc = 1'b1;
                end
            end
            S_FAULT: begin
                // Parked with the PLL in reset until software restarts the sequence.
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        // A software restart wins over every other transition and suppresses relock counting.
        if (sw_restart) begin
            state_d    = S_RESET_PLL;
            cnt_d      = '0;
            retry_d    = '0;
            relock_inc = 1'b0;
        end
    end

    // State, counter and retry registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RESET_PLL;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // Registered outputs decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pll_rst      <= 1'b1;
            pll_ready    <= 1'b0;
            fault        <= 1'b0;
            relock_count <= 8'd0;
        end else begin
            pll_rst   <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
            pll_ready <= (state_d == S_RUN);
            fault     <= (state_d == S_FAULT);
            if (relock_inc && (relock_count != 8'hFF)) begin
                relock_count <= relock_count + 8'd1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_soc_system_pwm_pll_ctrl.sv
// Self-checking bench for soc_system_pwm_pll_ctrl with small timing parameters.
`timescale 1ns/1ps
module tb_soc_system_pwm_pll_ctrl;

    localparam int RST_CYCLES          = 4;
    localparam int LOCK_STABLE_CYCLES  = 8;
    localparam int LOCK_TIMEOUT_CYCLES = 32;
    localparam int MAX_RETRIES         = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       sw_restart;
    logic       pll_rst;
    logic       pll_ready;
    logic       fault;
    logic [7:0] relock_count;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_relock = 0;

    typedef struct {
        logic locked;
        logic restart;
        int   cycles;
        int   st;
        logic rst;
        logic ready;
        logic flt;
        int   relock;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    soc_system_pwm_pll_ctrl #(
        .RST_CYCLES         (RST_CYCLES),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
        .MAX_RETRIES        (MAX_RETRIES),
        .CNT_W              (17)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .sw_restart  (sw_restart),
        .pll_rst     (pll_rst),
        .pll_ready   (pll_ready),
        .fault       (fault),
        .relock_count(relock_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One clock cycle; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Output relationships that must hold in every state.
    task automatic check_invariants();
        check("inv_pll_rst", int'(pll_rst), int'(state == 3'd0 || state == 3'd4));
        check("inv_ready",   int'(pll_ready), int'(state == 3'd3));
        check("inv_fault",   int'(fault), int'(state == 3'd4));
    endtask

    // Count consecutive samples (including the current one) spent in state st.
    task automatic count_run(input int st, input int max, output int n);
        n = 0;
        while (int'(state) == st && n < max) begin
            check_invariants();
            cyc();
            n++;
        end
    endtask

    // Wait for pll_ready to reach val; returns the number of cycles taken.
    task automatic wait_ready(input logic val, input int max, output int n);
        n = 0;
        while (pll_ready != val && n < max) begin
            cyc();
            n++;
        end
    endtask

    task automatic add(input logic l, input logic r, input int c, input int st,
                       input logic rst, input logic rdy, input logic f, input int rc);
        vec_t v;
        v.locked = l; v.restart = r; v.cycles = c; v.st = st;
        v.rst = rst; v.ready = rdy; v.flt = f; v.relock = rc;
        vecs.push_back(v);
    endtask

    initial begin
        int   n;
        int   timeouts;
        logic stayed;
        vec_t e;

        // Vectors: locked, restart, cycles, state, pll_rst, pll_ready, fault, relock_count.
        // Nominal lock from reset release (lock applied 3 cycles after pll_rst falls).
        add(0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 3, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 2, 1, 0, 0, 0, 0);
        add(1, 0, 2, 1, 0, 0, 0, 0);
        add(1, 0, 1, 2, 0, 0, 0, 0);
        add(1, 0, 7, 2, 0, 0, 0, 0);
        add(1, 0, 1, 3, 0, 1, 0, 0);
        add(1, 0, 5, 3, 0, 1, 0, 0);
        // Restart from RUN, then a glitchy lock: 5 high, 1 low, then steady.
        add(1, 1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 3, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0);
        add(1, 0, 2, 1, 0, 0, 0, 0);
        add(1, 0, 1, 2, 0, 0, 0, 0);
        add(1, 0, 2, 2, 0, 0, 0, 0);
        add(0, 0, 1, 2, 0, 0, 0, 0);
        add(1, 0, 1, 2, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 2, 0, 0, 0, 0);
        add(1, 0, 7, 2, 0, 0, 0, 0);
        add(1, 0, 1, 3, 0, 1, 0, 0);

        reset_n    = 1'b0;
        pll_locked = 1'b0;
        sw_restart = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state",  int'(state), 0);
        check("reset_pllrst", int'(pll_rst), 1);
        reset_n = 1'b1;

        // Table-driven nominal and glitch sequences through the scoreboard.
        for (int i = 0; i < vecs.size(); i++) begin
            pll_locked = vecs[i].locked;
            sw_restart = vecs[i].restart;
            exp_q.push_back(vecs[i]);
            repeat (vecs[i].cycles) cyc();
            e = exp_q.pop_front();
            check($sformatf("vec%0d_state", i), int'(state), e.st);
            check($sformatf("vec%0d_pll_rst", i), int'(pll_rst), int'(e.rst));
            check($sformatf("vec%0d_ready", i), int'(pll_ready), int'(e.ready));
            check($sformatf("vec%0d_fault", i), int'(fault), int'(e.flt));
            check($sformatf("vec%0d_relock", i), int'(relock_count), e.relock);
        end
        sw_restart = 1'b0;

        // Timeout to FAULT: two 32-cycle waits separated by a 4-cycle reset pulse.
        pll_locked = 1'b0;
        sw_restart = 1'b1;
        cyc();
        sw_restart = 1'b0;
        check("to_restart_state", int'(state), 0);
        count_run(0, 20, n);  check("to_rst1_len", n, RST_CYCLES);
        count_run(1, 100, n); check("to_wait1_len", n, LOCK_TIMEOUT_CYCLES);
        count_run(0, 20, n);  check("to_rst2_len", n, RST_CYCLES);
        count_run(1, 100, n); check("to_wait2_len", n, LOCK_TIMEOUT_CYCLES);
        check("to_fault_state", int'(state), 4);
        check("to_fault_flag", int'(fault), 1);
        check("to_fault_pllrst", int'(pll_rst), 1);
        check("to_fault_ready", int'(pll_ready), 0);
        stayed = 1'b1;
        repeat (40) begin
            cyc();
            if (state != 3'd4 || !pll_rst || !fault || pll_ready) stayed = 1'b0;
        end
        check("to_fault_held", int'(stayed), 1);

        // Recovery from FAULT via sw_restart.
        sw_restart = 1'b1;
        cyc();
        sw_restart = 1'b0;
        check("rec_fault_clear", int'(fault), 0);
        check("rec_state", int'(state), 0);
        pll_locked = 1'b1;
        count_run(0, 20, n);  check("rec_rst_len", n, RST_CYCLES);
        count_run(1, 100, n); check("rec_wait_bounded", int'(n < 100), 1);
        count_run(2, 20, n);  check("rec_stable_len", n, LOCK_STABLE_CYCLES);
        check("rec_run_state", int'(state), 3);
        check("rec_relock", int'(relock_count), exp_relock);

        // Three lock losses in RUN, 3 cycles each.
        for (int k = 0; k < 3; k++) begin
            pll_locked = 1'b0;
            wait_ready(1'b0, 10, n);
            check($sformatf("loss%0d_ready_lat", k), n, 3);
            pll_locked = 1'b1;
            exp_relock++;
            check($sformatf("loss%0d_relock", k), int'(relock_count), exp_relock);
            count_run(0, 20, n);  check($sformatf("loss%0d_rst_len", k), n, RST_CYCLES);
            count_run(1, 100, n);
            count_run(2, 20, n);  check($sformatf("loss%0d_stable_len", k), n, LOCK_STABLE_CYCLES);
            check($sformatf("loss%0d_run", k), int'(state), 3);
        end

        // sw_restart on the same cycle locked_s falls in RUN: no relock increment.
        pll_locked = 1'b0;
        cyc();
        cyc();
        sw_restart = 1'b1;
        cyc();
        sw_restart = 1'b0;
        pll_locked = 1'b1;
        check("simul_state", int'(state), 0);
        check("simul_ready", int'(pll_ready), 0);
        check("simul_relock", int'(relock_count), exp_relock);
        count_run(0, 20, n);  check("simul_rst_len", n, RST_CYCLES);
        count_run(1, 100, n);
        count_run(2, 20, n);  check("simul_stable_len", n, LOCK_STABLE_CYCLES);

        // Saturation: 257 further losses take the total to 260.
        timeouts = 0;
        for (int k = 0; k < 257; k++) begin
            pll_locked = 1'b0;
            repeat (3) cyc();
            pll_locked = 1'b1;
            wait_ready(1'b1, 100, n);
            if (n >= 100) timeouts++;
        end
        check("sat_timeouts", timeouts, 0);
        check("sat_relock", int'(relock_count), 255);

        // Asynchronous reset in the middle of STABLE_CHK.
        sw_restart = 1'b1;
        cyc();
        sw_restart = 1'b0;
        count_run(0, 20, n);
        count_run(1, 100, n);
        repeat (3) cyc();
        check("arst_pre_state", int'(state), 2);
        #2 reset_n = 1'b0;
        #1;
        check("arst_state",  int'(state), 0);
        check("arst_pllrst", int'(pll_rst), 1);
        check("arst_ready",  int'(pll_ready), 0);
        check("arst_fault",  int'(fault), 0);
        check("arst_relock", int'(relock_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        count_run(0, 20, n);  check("arst_rst_len", n, RST_CYCLES);
        count_run(1, 100, n);
        count_run(2, 20, n);  check("arst_stable_len", n, LOCK_STABLE_CYCLES);
        check("arst_run", int'(state), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_system_pwm_pll_ctrl.md
Name: soc_system_pwm_pll_ctrl

Overview:
Lock/reset sequencer for the PWM-domain PLL (50 MHz ref -> ~1.505 MHz PWM clock). Drives the PLL reset, qualifies its lock output (synchronised and held stable for a minimum time), and retries on lock timeout. Exposes a registered ready flag that gates PWM enable, plus fault and relock statistics for the Avalon status register. Runs entirely in the 50 MHz reference domain.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per reset attempt (>=2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before ready (>=2)
LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK before a retry (>=2)
MAX_RETRIES, 3, failed attempts allowed before FAULT (1..15)
CNT_W, 17, width of shared cycle counter; must hold max(RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)

Ports:
clk  in  1  50 MHz reference clock (same source as PLL refclk)
reset_n  in  1  asynchronous active-low reset
pll_locked  in  1  raw PLL locked; asynchronous to clk
sw_restart  in  1  single-cycle pulse; forces a fresh reset sequence
pll_rst  out  1  PLL reset, active-high
pll_ready  out  1  PLL output qualified; PWM may run
fault  out  1  retries exhausted; PLL held in reset
relock_count  out  8  lock-loss events seen in RUN, saturating
state  out  3  FSM encoding: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE_CHK, 3 RUN, 4 FAULT

Behaviour:
- Reset (reset_n low, asynchronous): state=RESET_PLL, pll_rst=1, pll_ready=0, fault=0, relock_count=0, retry=0, counter=0, sync flops=0.
- pll_locked passes through a 2-flop synchroniser to give locked_s (2-cycle latency). All outputs are registered.
- RESET_PLL: pll_rst=1. Counter increments each cycle. When counter==RST_CYCLES-1, go to WAIT_LOCK and clear the counter.
- WAIT_LOCK: pll_rst=0.
  - locked_s=1: go to STABLE_CHK, counter cleared.
  - Otherwise, when counter==LOCK_TIMEOUT_CYCLES-1: retry++. If the new retry==MAX_RETRIES, go to FAULT; else go to RESET_PLL.
- STABLE_CHK: pll_rst=0. Counter increments while locked_s=1.
  - locked_s=0: return to WAIT_LOCK, counter cleared. retry is unchanged and the timeout restarts.
  - counter==LOCK_STABLE_CYCLES-1 with locked_s=1: go to RUN and clear retry. pll_ready=1 from the first RUN cycle.
- RUN: pll_rst=0, pll_ready=1.
  - locked_s=0: pll_ready=0 on the next cycle, relock_count++ (saturates at 255), go to RESET_PLL.
- FAULT: pll_rst=1, fault=1, pll_ready=0. Stays until sw_restart.
- sw_restart in any state: next state=RESET_PLL, counter=0, retry=0, fault=0, pll_ready=0. relock_count is not cleared.
- Priority: sw_restart beats every other transition. In RUN, sw_restart together with locked_s=0 does not increment relock_count.
- sw_restart while already in RESET_PLL restarts the RST_CYCLES count.
- pll_ready and fault are never both 1.
- pll_rst=1 exactly in RESET_PLL and FAULT.
- Counter never wraps: every terminal compare forces a clear.

Test Plan:
Bench params: RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Nominal lock:
   - Stimulus: release reset; pll_locked=1 from 3 cycles after pll_rst falls.
   - Required: pll_rst high for exactly 4 cycles; state 0->1->2->3; pll_ready rises exactly 8 cycles after state enters 2; fault=0, relock_count=0.
2. Glitchy lock:
   - Stimulus: pll_locked pulses high 5 cycles, low 1 cycle, then high steady.
   - Required: STABLE_CHK aborts to WAIT_LOCK; pll_ready only after a full 8 consecutive locked_s cycles; retry stays 0.
3. Timeout/fault:
   - Stimulus: pll_locked held 0.
   - Required: two WAIT_LOCK windows of 32 cycles each, separated by a 4-cycle pll_rst pulse; then state=4, fault=1, pll_rst=1 permanently; pll_ready=0 throughout.
4. Recovery:
   - Stimulus: from FAULT, pulse sw_restart, then pll_locked=1.
   - Required: fault clears the next cycle; full sequence reaches RUN; relock_count unchanged.
5. Lock loss in RUN:
   - Stimulus: drop pll_locked for 3 cycles, 3 separate times.
   - Required: each time pll_ready falls 3 cycles after the pll_locked edge (2 sync + 1), and pll_rst pulses 4 cycles; relock_count=3.
   - Saturation: force 260 losses -> relock_count=255.
6. Simultaneous and async reset:
   - Stimulus: assert sw_restart on the same cycle locked_s falls in RUN. Separately, assert reset_n low mid-STABLE_CHK.
   - Required: relock_count is not incremented. All outputs go to reset values immediately, without waiting for a clk edge.
